core_sequencer: RTL and testbench

Multi-cycle control FSM for the RV32I core. It sequences program counter update, instruction fetch, decode, execute and writeback. It drives the instruction-memory request handshake, latches the fetched instruction for the decoder, and issues one-cycle stage enables. It also applies branch/jump redirects, counts retired instructions, and halts on fetch timeout or misaligned targets.

---
 rtl/core_sequencer.sv | 155 +++++++++++++++
 tb/tb_core_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for an RV32I core: fetch, decode, execute, writeback.
// Owns the PC, the fetched instruction latch, the retire counter and a sticky fault flag.
module core_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] PC_STEP       = 32'd4,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        run_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic        dec_en_o,
  output logic        ex_en_o,
  input  logic        rd_valid_i,
  input  logic [4:0]  rd_i,
  input  logic        take_branch_i,
  input  logic [31:0] branch_target_i,
  output logic        wb_en_o,
  output logic        retired_o,
  output logic [31:0] instret_o,
  output logic [31:0] pc_o,
  output logic        fault_o,
  output logic [2:0]  state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam logic [31:0] TIMEOUT_LAST = 32'(FETCH_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] next_pc_q;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic [31:0] cnt_q;
  logic        fault_q;
  logic        imem_req_q;
  logic        dec_en_q;
  logic        ex_en_q;
  logic        wb_en_q;
  logic        retired_q;

  logic timeout_hit;
  logic misaligned;
  logic rd_writes;

  assign timeout_hit = (FETCH_TIMEOUT != 0) && (cnt_q == TIMEOUT_LAST);
  assign misaligned  = take_branch_i && (branch_target_i[1:0] != 2'b00);
  assign rd_writes   = rd_valid_i && (rd_i != 5'd0);

  // Strobes are registered: each is set on the transition into the state that owns it,
  // so it is high for exactly the cycles the FSM spends in that state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      next_pc_q  <= RESET_PC;
      instr_q    <= 32'd0;
      instret_q  <= 32'd0;
      cnt_q      <= 32'd0;
      fault_q    <= 1'b0;
      imem_req_q <= 1'b0;
      dec_en_q   <= 1'b0;
      ex_en_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      retired_q  <= 1'b0;
    end else begin
      imem_req_q <= 1'b0;
      dec_en_q   <= 1'b0;
      ex_en_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      retired_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          if (imem_ready_i) begin
            instr_q  <= imem_rdata_i;
            cnt_q    <= 32'd0;
            state_q  <= S_DECODE;
            dec_en_q <= 1'b1;
          end else if (timeout_hit) begin
            cnt_q   <= 32'd0;
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            cnt_q      <= cnt_q + 32'd1;
            imem_req_q <= 1'b1;
          end
        end
        S_DECODE: begin
          state_q <= S_EXECUTE;
          ex_en_q <= 1'b1;
        end
        S_EXECUTE: begin
          if (misaligned) begin
            fault_q <= 1'b1;
            state_q <= S_HALT;
          end else begin
            next_pc_q <= take_branch_i ? branch_target_i : pc_q + PC_STEP;
            state_q   <= S_WRITEBACK;
            // Decoder outputs are registered and already valid in EXECUTE.
            wb_en_q   <= rd_writes;
            retired_q <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          pc_q      <= next_pc_q;
          instret_q <= instret_q + 32'd1;
          if (run_i) begin
            state_q    <= S_FETCH;
            imem_req_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_HALT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = pc_q;
  assign instr_o     = instr_q;
  assign dec_en_o    = dec_en_q;
  assign ex_en_o     = ex_en_q;
  assign wb_en_o     = wb_en_q;
  assign retired_o   = retired_q;
  assign instret_o   = instret_q;
  assign pc_o        = pc_q;
  assign fault_o     = fault_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: directed instruction vectors push expected
// fetch addresses and retire records; a negedge monitor pops and compares them.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        run_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic        dec_en_o;
  logic        ex_en_o;
  logic        rd_valid_i;
  logic [4:0]  rd_i;
  logic        take_branch_i;
  logic [31:0] branch_target_i;
  logic        wb_en_o;
  logic        retired_o;
  logic [31:0] instret_o;
  logic [31:0] pc_o;
  logic        fault_o;
  logic [2:0]  state_o;

  core_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .run_i          (run_i),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_ready_i   (imem_ready_i),
    .imem_rdata_i   (imem_rdata_i),
    .instr_o        (instr_o),
    .dec_en_o       (dec_en_o),
    .ex_en_o        (ex_en_o),
    .rd_valid_i     (rd_valid_i),
    .rd_i           (rd_i),
    .take_branch_i  (take_branch_i),
    .branch_target_i(branch_target_i),
    .wb_en_o        (wb_en_o),
    .retired_o      (retired_o),
    .instret_o      (instret_o),
    .pc_o           (pc_o),
    .fault_o        (fault_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wb;
    logic [31:0] cnt;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] fetch_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc = 0;
  int          exp_gap = -1;
  int          last_start = 0;
  logic [31:0] exp_instret = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Monitor: sampled mid-cycle, between the driver's updates and the DUT's sampling edge.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (imem_req_o && imem_ready_i) begin
        if (fetch_q.size() == 0) begin
          n_total++;
          $display("FAIL fetch_sb: unexpected fetch at 0x%08h, none expected", imem_addr_o);
        end else begin
          chk("fetch_addr", imem_addr_o, fetch_q.pop_front());
        end
      end
      if (retired_o) begin
        if (ret_q.size() == 0) begin
          n_total++;
          $display("FAIL retire_sb: unexpected retire of pc 0x%08h, none expected", pc_o);
        end else begin
          ret_t r;
          r = ret_q.pop_front();
          chk("retire_pc", pc_o, r.pc);
          chk("retire_instr", instr_o, r.instr);
          chk("retire_wb_en", 32'(wb_en_o), 32'(r.wb));
          chk("retire_instret", instret_o, r.cnt);
        end
      end
      chk("wb_only_with_retire", 32'(wb_en_o & ~retired_o), 32'd0);
    end
  end

  task automatic do_instr(input logic [31:0] addr, input int waits, input logic [31:0] rdata,
                          input logic take, input logic [31:0] target,
                          input logic rv, input logic [4:0] rdn, input logic drop_run);
    bit   seen;
    logic mis;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (imem_req_o) seen = 1;
      else tick();
    end
    chk("fetch_start", 32'(seen), 32'd1);
    if (!seen) return;
    if (exp_gap >= 0) chk("cycles_per_instr", 32'(cyc - last_start), 32'(exp_gap));
    last_start = cyc;
    chk("fetch_pc", pc_o, addr);
    chk("fetch_instret", instret_o, exp_instret);
    take_branch_i   = take;
    branch_target_i = target;
    rd_valid_i      = rv;
    rd_i            = rdn;
    for (int i = 0; i < waits; i++) begin
      imem_ready_i = 1'b0;
      tick();
      chk("addr_stable", imem_addr_o, addr);
      chk("req_held", 32'(imem_req_o), 32'd1);
    end
    mis = take && (target[1:0] != 2'b00);
    fetch_q.push_back(addr);
    if (!mis) begin
      ret_q.push_back('{pc: addr, instr: rdata, wb: rv && (rdn != 5'd0), cnt: exp_instret});
      exp_instret++;
    end
    exp_gap = (mis || drop_run) ? -1 : 4 + waits;
    imem_ready_i = 1'b1;
    imem_rdata_i = rdata;
    tick();
    imem_ready_i = 1'b0;
    if (drop_run) run_i = 1'b0;
  endtask

  task automatic reset_dut();
    rst_ni = 1'b0;
    run_i = 1'b0;
    imem_ready_i = 1'b0;
    take_branch_i = 1'b0;
    rd_valid_i = 1'b0;
    tick();
    tick();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_instret", instret_o, 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_pulses", {28'd0, dec_en_o, ex_en_o, wb_en_o, retired_o}, 32'd0);
    rst_ni = 1'b1;
    exp_gap = -1;
    exp_instret = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    run_i = 1'b0;
    imem_ready_i = 1'b0;
    imem_rdata_i = 32'd0;
    rd_valid_i = 1'b0;
    rd_i = 5'd0;
    take_branch_i = 1'b0;
    branch_target_i = 32'd0;
    reset_dut();
    chk("rst_instr", instr_o, 32'd0);
    run_i = 1'b1;

    do_instr(32'h0000_0000, 0, 32'h0000_0013, 1'b0, 32'h0,         1'b1, 5'd0, 1'b0);
    do_instr(32'h0000_0004, 0, 32'h0050_0293, 1'b0, 32'h0,         1'b1, 5'd5, 1'b0);
    do_instr(32'h0000_0008, 0, 32'h0200_0c63, 1'b1, 32'h40,        1'b0, 5'd5, 1'b0);
    do_instr(32'h0000_0040, 3, 32'h0070_0113, 1'b1, 32'hFFFF_FFFC, 1'b1, 5'd2, 1'b0);
    do_instr(32'hFFFF_FFFC, 0, 32'h0010_0093, 1'b0, 32'h0,         1'b1, 5'd1, 1'b0);
    do_instr(32'h0000_0000, 14, 32'h0030_0193, 1'b0, 32'h0,        1'b1, 5'd3, 1'b1);

    // run dropped in DECODE: instruction still retires, then the FSM parks.
    tick(); tick(); tick(); tick();
    chk("park_state", 32'(state_o), 32'd0);
    chk("park_pc", pc_o, 32'h0000_0004);
    chk("park_req", 32'(imem_req_o), 32'd0);
    chk("park_instret", instret_o, exp_instret);

    run_i = 1'b1;
    do_instr(32'h0000_0004, 0, 32'h0000_0063, 1'b1, 32'h42, 1'b0, 5'd0, 1'b0);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_req_low", 32'(imem_req_o), 32'd0);
      tick();
    end
    chk("mis_state", 32'(state_o), 32'd5);
    chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_pc", pc_o, 32'h0000_0004);
    chk("mis_instret", instret_o, exp_instret);

    // Fetch timeout: 15 cycles without imem_ready.
    reset_dut();
    run_i = 1'b1;
    for (int n = 0; n < 10 && !imem_req_o; n++) tick();
    chk("to_fetch", 32'(state_o), 32'd1);
    for (int i = 0; i < 14; i++) tick();
    chk("to_last_cycle_state", 32'(state_o), 32'd1);
    tick();
    chk("to_state", 32'(state_o), 32'd5);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_req", 32'(imem_req_o), 32'd0);
    tick(); tick();
    chk("to_fault_sticky", 32'(fault_o), 32'd1);

    // Asynchronous reset mid-fetch.
    reset_dut();
    run_i = 1'b1;
    for (int n = 0; n < 10 && !imem_req_o; n++) tick();
    tick();
    chk("mid_req_before", 32'(imem_req_o), 32'd1);
    rst_ni = 1'b0;
    run_i = 1'b0;
    #1;
    chk("mid_req_async", 32'(imem_req_o), 32'd0);
    chk("mid_state_async", 32'(state_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk("post_pc", pc_o, 32'h0);
    chk("post_instret", instret_o, 32'd0);
    chk("post_fault", 32'(fault_o), 32'd0);

    chk("fetch_sb_drained", 32'(fetch_q.size()), 32'd0);
    chk("retire_sb_drained", 32'(ret_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
